uart_rx_fifo: RTL and testbench

// - Receive-side buffer directly downstream of the UART receiver. Captures each
//   one-cycle receive strobe (data byte plus BREAK flag) into a DEPTH-entry FIFO.
// - Presents entries to the host/bus side through a valid/ready interface.
// - Reports fill level and a sticky overflow flag, so a slow consumer never

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_fifo_mem.sv | 43 ++++
 rtl/uart_rx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//
// Types and constants shared by the UART receive path.
//   PAYLOAD_BITS    default data bits per received character (shared with the
//                   receiver so both sides agree on the byte width)
//   DEFAULT_DEPTH   default receive FIFO depth
//   uart_rx_entry_t one FIFO entry: BREAK tag above the data byte
//   entry_bits()    width of a packed entry for a given payload width
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int PAYLOAD_BITS  = 8;
    localparam int DEFAULT_DEPTH = 16;

    typedef struct packed {
        logic                    brk;
        logic [PAYLOAD_BITS-1:0] data;
    } uart_rx_entry_t;

    // Entries are stored as raw vectors with the same layout as
    // uart_rx_entry_t (brk in the MSB), so non-default payload widths work.
    function automatic int entry_bits(input int payload_bits);
        return payload_bits + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
//
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous (combinational) read port. Holds no pointer or flag state;
// the owning FIFO decides what is valid.
//
// Ports
//   clk    in   system clock, writes on posedge
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index
//   rdata  out  contents at raddr, combinational
// ---------------------------------------------------------------------------
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int WIDTH = entry_bits(PAYLOAD_BITS),
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are not reset: the FIFO masks the read data while empty, so
    // stale or unknown slots are never presented.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side buffer behind the UART receiver. Each one-cycle receive strobe
// (byte plus BREAK tag) is written into a DEPTH-entry first-word-fall-through
// FIFO and offered to the host through a valid/ready port. A byte that
// arrives while the FIFO is full (and no slot frees in the same cycle) is
// dropped and recorded in a sticky overflow flag.
//
// Handshake: the input side is a strobe only (in_valid is never
// back-pressured). On the output side an entry transfers on every rising
// edge where out_valid && out_ready; out_data/out_break hold steady while
// out_valid=1 and out_ready=0, and out_ready while empty has no effect.
//
// Ports
//   clk           in   system clock, posedge
//   resetn        in   asynchronous active-low reset, discards all contents
//   in_valid      in   receiver strobe: new byte present
//   in_data       in   received byte
//   in_break      in   BREAK condition tag for this strobe
//   out_valid     out  head entry available
//   out_ready     in   consumer takes the head entry
//   out_data      out  head data (0 while empty)
//   out_break     out  head BREAK tag (0 while empty)
//   count         out  entries held, 0..DEPTH
//   full          out  count == DEPTH
//   overflow      out  sticky: a byte was dropped
//   overflow_clr  in   pulse clears overflow (a same-cycle drop wins)
//
// Build option
//   UART_RX_FIFO_BREAK_FLUSH_EN: a BREAK strobe flushes the FIFO and becomes
//   its only entry; it is accepted even when full and never sets overflow.
//   Without it a BREAK is an ordinary tagged entry.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter  int PAYLOAD_BITS = uart_pkg::PAYLOAD_BITS,
    parameter  int DEPTH        = uart_pkg::DEFAULT_DEPTH,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    input  logic [PAYLOAD_BITS-1:0] in_data,
    input  logic                    in_break,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PAYLOAD_BITS-1:0] out_data,
    output logic                    out_break,
    output logic [AW:0]             count,
    output logic                    full,
    output logic                    overflow,
    input  logic                    overflow_clr
);

    import uart_pkg::*;

    localparam int EW = entry_bits(PAYLOAD_BITS);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          empty;
    logic          full_w;
    logic          pop_req;
    logic          pop;
    logic          push;
    logic          flush;
    logic          drop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    assign empty   = (wr_q == rd_q);
    assign full_w  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_req = out_ready && !empty;

`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
    assign flush = in_valid && in_break;
`else
    assign flush = 1'b0;
`endif

    // Same layout as uart_rx_entry_t: BREAK tag above the data byte.
    assign wr_entry = {in_break, in_data};

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        pop     = 1'b0;
        push    = 1'b0;

        if (flush) begin
            // Old contents are discarded by moving rd onto wr; the BREAK
            // entry written at wr becomes the only entry. A same-cycle pop
            // is meaningless here and is ignored.
            push    = 1'b1;
            rd_d    = wr_q;
            wr_d    = wr_q + 1'b1;
            count_d = {{AW{1'b0}}, 1'b1};
        end else begin
            pop  = pop_req;
            // A pop in the same cycle frees the head slot, so a full FIFO
            // still accepts the incoming byte.
            push = in_valid && (!full_w || pop_req);
            if (push) begin
                wr_d = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        drop = in_valid && !push;

        // A drop in the same cycle as a clear pulse keeps the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (overflow_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    uart_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_q[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_q[AW-1:0]),
        .rdata (rd_entry)
    );

    // Head is read straight from the array (fall-through); masked while
    // empty so the port reads zero after reset and between bursts.
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : rd_entry[PAYLOAD_BITS-1:0];
    assign out_break = !empty && rd_entry[EW-1];
    assign count     = count_q;
    assign full      = full_w;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed plus randomised stimulus for uart_rx_fifo. Accepted entries are
// pushed to exp_q; the head and every pop are compared against it.
// Build option UART_RX_FIFO_BREAK_FLUSH_EN selects the flush expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int PB    = 8;
    localparam int AW    = $clog2(DEPTH);

    // clock / reset
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // DUT signals
    logic          in_valid;
    logic [PB-1:0] in_data;
    logic          in_break;
    logic          out_valid;
    logic          out_ready;
    logic [PB-1:0] out_data;
    logic          out_break;
    logic [AW:0]   count;
    logic          full;
    logic          overflow;
    logic          overflow_clr;

    uart_rx_fifo #(
        .PAYLOAD_BITS (PB),
        .DEPTH        (DEPTH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_break     (in_break),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_break    (out_break),
        .count        (count),
        .full         (full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    // scoreboard
    logic [PB:0] exp_q[$];
    logic        ovf_m;
    logic [PB:0] last_pop;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus. Called at posedge+1; checks the head before the
    // edge, updates the model, then checks count/full/overflow after it.
    task automatic cycle(input logic v, input logic [PB-1:0] d, input logic b,
                         input logic rdy, input logic clr);
        logic full_m, pop_m, push_m, flush_m;
        in_valid     = v;
        in_data      = d;
        in_break     = b;
        out_ready    = rdy;
        overflow_clr = clr;
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            chk("head", {23'd0, out_break, out_data}, {23'd0, exp_q[0]});
        end
        full_m  = (exp_q.size() == DEPTH);
        pop_m   = rdy && (exp_q.size() != 0);
        flush_m = 1'b0;
`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
        flush_m = v && b;
`endif
        push_m = v && (!full_m || pop_m);
        if (flush_m) begin
            exp_q.delete();
            exp_q.push_back({b, d});
        end else begin
            if (pop_m) begin
                last_pop = {out_break, out_data};
                void'(exp_q.pop_front());
            end
            if (push_m) begin
                exp_q.push_back({b, d});
            end
        end
        if (v && !push_m && !flush_m) begin
            ovf_m = 1'b1;
        end else if (clr) begin
            ovf_m = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_break     = 1'b0;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        chk("count", {27'd0, count}, exp_q.size());
        chk("full", {31'd0, full}, {31'd0, exp_q.size() == DEPTH});
        chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (exp_q.size() != 0) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        ovf_m        = 1'b0;
        last_pop     = '0;
        resetn       = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_break     = 1'b0;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;

        // reset state
        #12;
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_break", {31'd0, out_break}, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // out_ready while empty has no effect
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // three bytes, held, then popped in order
        cycle(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
        chk("three_count", {27'd0, count}, 32'd3);
        chk("three_head", {24'd0, out_data}, 32'h41);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("three_last", {23'd0, last_pop}, 32'h043);
        chk("three_empty", {31'd0, out_valid}, 32'd0);

        // fill, then drop 0x99
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        chk("fill_full", {31'd0, full}, 32'd1);
        cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        chk("drop_ovf", {31'd0, overflow}, 32'd1);
        chk("drop_count", {27'd0, count}, 32'd16);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", {31'd0, overflow}, 32'd0);
        // drop and clear together: set wins
        cycle(1'b1, 8'h9A, 1'b0, 1'b0, 1'b1);
        chk("set_wins", {31'd0, overflow}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // full with same-cycle pop accepts 0x55
        cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        chk("full_pop_count", {27'd0, count}, 32'd16);
        chk("full_pop_ovf", {31'd0, overflow}, 32'd0);
        drain();
        chk("last_is_55", {23'd0, last_pop}, 32'h055);

        // continuous push/pop across pointer wrap
        cycle(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0, 1'b1, 1'b0);
        drain();
        chk("stream_last", {23'd0, last_pop}, 32'h038);

        // random traffic, biased to reach full and overflow
        for (int i = 0; i < 120; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 1'b0,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
        end
        drain();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // BREAK behind two queued bytes
        cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
        chk("brk_count", {27'd0, count}, 32'd1);
        chk("brk_head", {31'd0, out_break}, 32'd1);
`else
        chk("brk_count", {27'd0, count}, 32'd3);
        chk("brk_head", {31'd0, out_break}, 32'd0);
`endif
        drain();
        chk("brk_last", {23'd0, last_pop}, 32'h100);

        // reset mid-burst at count=5
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", {27'd0, count}, 32'd5);
        resetn = 1'b0;
        #2;
        chk("mid_rst_count", {27'd0, count}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        exp_q.delete();
        ovf_m = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("post_rst_head", {24'd0, out_data}, 32'h5A);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // bound on total run time
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
